// File: rtl/div_ctrl_if.sv
// Divide controller handshake bundle: E-stage request/operands in, stall/ready/result out.
interface div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             div_startE;
  logic             signed_divE;
  logic [WIDTH-1:0] opaE;
  logic [WIDTH-1:0] opbE;
  logic             stall_in;
  logic             flush;
  logic             stall_divE;
  logic             div_readyE;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  // Pipeline side: issues requests, consumes stall and result.
  modport master (
    output div_startE, signed_divE, opaE, opbE, stall_in, flush,
    input  stall_divE, div_readyE, hi_out, lo_out
  );

  // Divider side.
  modport slave (
    input  div_startE, signed_divE, opaE, opbE, stall_in, flush,
    output stall_divE, div_readyE, hi_out, lo_out
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring divide on magnitudes with sign
// pre/post-correction, divide stall to the hazard unit, and a result held while E is stalled.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         resetn,
  div_ctrl_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  state_t           state;
  logic [CntW-1:0]  counter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;         // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividendRaw;  // unsigned raw opa, returned as remainder on divide by zero
  logic             divByZero;
  logic             negQuot;
  logic             negRem;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quotNext;
  logic [WIDTH-1:0] hiFinal;
  logic [WIDTH-1:0] loFinal;

  // Operand magnitudes and signs; signs are ignored for DIVU.
  always_comb begin
    signA = bus.signed_divE & bus.opaE[WIDTH-1];
    signB = bus.signed_divE & bus.opbE[WIDTH-1];
    absA  = signA ? (~bus.opaE + WIDTH'(1)) : bus.opaE;
    absB  = signB ? (~bus.opbE + WIDTH'(1)) : bus.opbE;
  end

  // One restoring step plus the sign-corrected result used on the final step.
  always_comb begin
    remShift = {rem, quot[WIDTH-1]};
    diff     = remShift - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      remNext  = diff[WIDTH-1:0];
      quotNext = {quot[WIDTH-2:0], 1'b1};
    end else begin
      remNext  = remShift[WIDTH-1:0];
      quotNext = {quot[WIDTH-2:0], 1'b0};
    end
    if (divByZero) begin
      hiFinal = dividendRaw;
      loFinal = '1;
    end else begin
      hiFinal = negRem  ? (~remNext + WIDTH'(1))  : remNext;
      loFinal = negQuot ? (~quotNext + WIDTH'(1)) : quotNext;
    end
  end

  // Controller state, datapath registers and the held result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= StIdle;
      counter     <= '0;
      rem         <= '0;
      quot        <= '0;
      divisor     <= '0;
      dividendRaw <= '0;
      divByZero   <= 1'b0;
      negQuot     <= 1'b0;
      negRem      <= 1'b0;
      hiReg       <= '0;
      loReg       <= '0;
    end else if (bus.flush) begin
      state <= StIdle;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.div_startE) begin
            rem         <= '0;
            quot        <= absA;
            divisor     <= absB;
            dividendRaw <= bus.opaE;
            divByZero   <= (bus.opbE == '0);
            negQuot     <= signA ^ signB;
            negRem      <= signA;
            counter     <= '0;
            state       <= StBusy;
          end
        end
        StBusy: begin
          rem     <= remNext;
          quot    <= quotNext;
          counter <= counter + 1'b1;
          if (counter == CntW'(WIDTH - 1)) begin
            hiReg <= hiFinal;
            loReg <= loFinal;
            state <= StDone;
          end
        end
        StDone: begin
          if (!bus.stall_in) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Stall and ready are decoded from state; flush kills both in the same cycle.
  always_comb begin
    bus.stall_divE = ((state == StIdle && bus.div_startE) || state == StBusy) && !bus.flush;
    bus.div_readyE = (state == StDone) && !bus.flush;
    bus.hi_out     = hiReg;
    bus.lo_out     = loReg;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed and random divides against an arithmetic model,
// plus flush, stall-hold, back-to-back and asynchronous reset scenarios.
module tb_div_ctrl;

  localparam int unsigned W = 32;

  logic clk;
  logic resetn;
  int   nTests;
  int   nFail;
  logic [W-1:0] prevHi;
  logic [W-1:0] prevLo;

  div_ctrl_if #(.WIDTH(W)) bus ();

  div_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero, remainder takes dividend sign.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 0) begin
      hi = a;
      lo = '1;
    end else begin
      sa = sgn ? longint'($signed(a)) : longint'(a);
      sb = sgn ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      hi = r[W-1:0];
      lo = q[W-1:0];
    end
  endfunction

  // Issue a divide in the current (idle) cycle; hold the result in DONE for holdN extra cycles.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int holdN, input string name);
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
    int stallCnt;
    int readyCnt;
    bit gotReady;
    model(a, b, sgn, expHi, expLo);
    bus.div_startE  = 1'b1;
    bus.signed_divE = sgn;
    bus.opaE        = a;
    bus.opbE        = b;
    bus.stall_in    = (holdN > 0);
    #1;
    stallCnt = bus.stall_divE ? 1 : 0;
    @(posedge clk); #1;
    bus.div_startE = 1'b0;
    bus.opaE       = $urandom;
    bus.opbE       = $urandom;
    gotReady = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.div_readyE) begin
        gotReady = 1;
        break;
      end
      if (bus.stall_divE) stallCnt++;
      if (bus.hi_out !== prevHi || bus.lo_out !== prevLo) begin
        nTests++; nFail++;
        $display("FAIL %s hold-while-busy: got hi=%h lo=%h, want hi=%h lo=%h",
                 name, bus.hi_out, bus.lo_out, prevHi, prevLo);
      end
    end
    nTests++;
    if (!gotReady) begin
      nFail++;
      $display("FAIL %s ready-timeout: got no div_readyE within 200 cycles, want ready", name);
    end
    nTests++;
    if (stallCnt !== W + 1) begin
      nFail++;
      $display("FAIL %s stall-cycles: got %0d, want %0d", name, stallCnt, W + 1);
    end
    nTests++;
    if (bus.hi_out !== expHi || bus.lo_out !== expLo) begin
      nFail++;
      $display("FAIL %s result (a=%h b=%h s=%0b): got hi=%h lo=%h, want hi=%h lo=%h",
               name, a, b, sgn, bus.hi_out, bus.lo_out, expHi, expLo);
    end
    readyCnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.div_readyE) break;
      readyCnt++;
      if (bus.hi_out !== expHi || bus.lo_out !== expLo || bus.stall_divE !== 1'b0) begin
        nTests++; nFail++;
        $display("FAIL %s done-hold: got hi=%h lo=%h stall=%b, want hi=%h lo=%h stall=0",
                 name, bus.hi_out, bus.lo_out, bus.stall_divE, expHi, expLo);
      end
      @(posedge clk); #1;
      if (readyCnt >= holdN) bus.stall_in = 1'b0;
      @(negedge clk);
    end
    nTests++;
    if (readyCnt !== holdN + 1) begin
      nFail++;
      $display("FAIL %s ready-cycles: got %0d, want %0d", name, readyCnt, holdN + 1);
    end
    prevHi = expHi;
    prevLo = expLo;
  endtask

  task automatic test_reset();
    bus.div_startE = 0; bus.signed_divE = 0; bus.opaE = 0; bus.opbE = 0;
    bus.stall_in = 0; bus.flush = 0;
    resetn = 1'b0;
    #3;
    nTests++;
    if (bus.hi_out !== '0 || bus.lo_out !== '0 || bus.stall_divE !== 1'b0 ||
        bus.div_readyE !== 1'b0) begin
      nFail++;
      $display("FAIL reset-values: got hi=%h lo=%h stall=%b ready=%b, want all 0",
               bus.hi_out, bus.lo_out, bus.stall_divE, bus.div_readyE);
    end
    prevHi = '0;
    prevLo = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'h2, 1'b1, 0, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_min_m1");
    run_div(32'd5, 32'd0, 1'b0, 0, "divu_5_0");
    run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 0, "div_m7_0");
  endtask

  task automatic test_flush();
    bus.div_startE = 1'b1; bus.signed_divE = 1'b0; bus.opaE = 32'd100; bus.opbE = 32'd7;
    bus.flush = 1'b1;
    #1;
    nTests++;
    if (bus.stall_divE !== 1'b0) begin
      nFail++;
      $display("FAIL flush-vs-start stall: got %b, want 0", bus.stall_divE);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    // Start still asserted; must be accepted now, proving the flushed request was not.
    @(posedge clk); #1;
    bus.div_startE = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    #1;
    nTests++;
    if (bus.stall_divE !== 1'b0 || bus.div_readyE !== 1'b0) begin
      nFail++;
      $display("FAIL flush-busy comb: got stall=%b ready=%b, want 0 0",
               bus.stall_divE, bus.div_readyE);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    nTests++;
    if (bus.stall_divE !== 1'b0) begin
      nFail++;
      $display("FAIL flush-next-idle stall: got %b, want 0", bus.stall_divE);
    end
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (bus.div_readyE !== 1'b0 || bus.stall_divE !== 1'b0 ||
          bus.hi_out !== prevHi || bus.lo_out !== prevLo) begin
        nTests++; nFail++;
        $display("FAIL flush-after cyc%0d: got rdy=%b stall=%b hi=%h lo=%h, want 0 0 %h %h",
                 c, bus.div_readyE, bus.stall_divE, bus.hi_out, bus.lo_out, prevHi, prevLo);
      end
    end
    nTests++;
  endtask

  task automatic test_back_to_back();
    run_div(32'd100, 32'd7, 1'b0, 3, "divu_hold3");
    run_div(32'd9, 32'd3, 1'b0, 0, "divu_9_3_b2b");
  endtask

  task automatic test_async_reset();
    bus.div_startE = 1'b1; bus.signed_divE = 1'b0; bus.opaE = 32'd77; bus.opbE = 32'd5;
    @(posedge clk); #1;
    bus.div_startE = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    nTests++;
    if (bus.hi_out !== '0 || bus.lo_out !== '0 || bus.stall_divE !== 1'b0 ||
        bus.div_readyE !== 1'b0) begin
      nFail++;
      $display("FAIL async-reset: got hi=%h lo=%h stall=%b ready=%b, want all 0",
               bus.hi_out, bus.lo_out, bus.stall_divE, bus.div_readyE);
    end
    prevHi = '0;
    prevLo = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_div(32'd10, 32'd3, 1'b0, 0, "divu_10_3_post_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (i % 6 == 0) a = 32'h8000_0000;
      run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
